dft_bin_unloader: RTL and testbench

- Output-side companion to the 16-point OBC DFT core. The core emits one complex bin (32-bit real, 32-bit imag) per strobe.
- This block captures each 16-bin frame into a ping-pong buffer and drains it to downstream logic over a valid/ready stream with bin index and last flag.
- Decouples DFT output timing from consumer backpressure. Flags lost and misaligned frames.

---
 rtl/dft_bin_unloader.sv | 177 +++++++++++++++++
 tb/tb_dft_bin_unloader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dft_bin_unloader.sv
// dft_bin_unloader
//   Captures 16-bin complex frames from the OBC DFT core into a ping-pong buffer and
//   drains them over a valid/ready stream, decoupling DFT timing from consumer backpressure.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   real_value, imag_value   bin from the DFT (two's complement, DW bits each)
//   bin_valid, bin_first     bin strobe; bin_first marks index 0 of a frame
//   out_real, out_imag       drained bin (zero while out_valid is low)
//   out_index, out_last      bin index of the beat; high on index NBINS-1
//   out_valid, out_ready     output stream handshake
//   overflow                 sticky: a whole frame was dropped, no bank free
//   sync_err                 sticky: bin_first seen mid-frame (partial frame abandoned)
//   clr_flags                clears both sticky flags (a same-cycle set wins)
//   out_mag                  only with MAG_EST_EN: max(|re|,|im|) + min(|re|,|im|)/2, saturated
//
// Optional feature macro: MAG_EST_EN
module dft_bin_unloader #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NBINS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            real_value,
  input  logic [DW-1:0]            imag_value,
  input  logic                     bin_valid,
  input  logic                     bin_first,
  output logic [DW-1:0]            out_real,
  output logic [DW-1:0]            out_imag,
  output logic [$clog2(NBINS)-1:0] out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
`ifdef MAG_EST_EN
  output logic [DW-1:0]            out_mag,
`endif
  output logic                     overflow,
  output logic                     sync_err,
  input  logic                     clr_flags
);

  localparam int unsigned IW = $clog2(NBINS);
  localparam logic [IW-1:0] IdxLast = IW'(NBINS - 1);

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkDraining} bank_st_e;

  bank_st_e bank_q [2];
  bank_st_e bank_d [2];

  logic [DW-1:0] mem_re [2][NBINS];
  logic [DW-1:0] mem_im [2][NBINS];

  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic          discard_q, discard_d;
  logic          overflow_q, sync_err_q;

  logic          xfer, we, ovf_set, sync_set, disc;
  logic [IW-1:0] eff_idx;

  assign out_valid = (bank_q[rd_bank_q] == BkFull) || (bank_q[rd_bank_q] == BkDraining);
  assign xfer      = out_valid && out_ready;

  // Read side is resolved first so a bank freed by the last beat can be claimed in the
  // same cycle by an incoming first bin.
  always_comb begin
    bank_d    = bank_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    discard_d = discard_q;
    we        = 1'b0;
    ovf_set   = 1'b0;
    sync_set  = 1'b0;
    disc      = discard_q;
    eff_idx   = wr_idx_q;

    if (xfer) begin
      if (rd_idx_q == IdxLast) begin
        bank_d[rd_bank_q] = BkEmpty;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        bank_d[rd_bank_q] = BkDraining;
        rd_idx_d          = rd_idx_q + 1'b1;
      end
    end

    if (bin_valid) begin
      if (bin_first && (wr_idx_q != '0)) begin
        // Realign: drop the partial frame; only release the bank if we actually held it.
        sync_set = 1'b1;
        eff_idx  = '0;
        if (!discard_q) bank_d[wr_bank_q] = BkEmpty;
        disc = 1'b0;
      end
      if (eff_idx == '0) begin
        if (bank_d[wr_bank_q] == BkEmpty) begin
          bank_d[wr_bank_q] = BkFilling;
          disc              = 1'b0;
        end else begin
          disc    = 1'b1;
          ovf_set = 1'b1;
        end
      end
      we = !disc;
      if (eff_idx == IdxLast) begin
        // wr_bank only advances on a completed frame, so drained order follows arrival order.
        if (!disc) begin
          bank_d[wr_bank_q] = BkFull;
          wr_bank_d         = ~wr_bank_q;
        end
        discard_d = 1'b0;
        wr_idx_d  = '0;
      end else begin
        discard_d = disc;
        wr_idx_d  = eff_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0]  <= BkEmpty;
      bank_q[1]  <= BkEmpty;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      discard_q  <= 1'b0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      discard_q  <= discard_d;
      overflow_q <= (overflow_q && !clr_flags) || ovf_set;
      sync_err_q <= (sync_err_q && !clr_flags) || sync_set;
    end
  end

  // Storage needs no reset: reads are gated by bank state.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_re[wr_bank_q][eff_idx] <= real_value;
      mem_im[wr_bank_q][eff_idx] <= imag_value;
    end
  end

  assign overflow  = overflow_q;
  assign sync_err  = sync_err_q;
  assign out_real  = out_valid ? mem_re[rd_bank_q][rd_idx_q] : '0;
  assign out_imag  = out_valid ? mem_im[rd_bank_q][rd_idx_q] : '0;
  assign out_index = out_valid ? rd_idx_q : '0;
  assign out_last  = out_valid && (rd_idx_q == IdxLast);

`ifdef MAG_EST_EN
  logic [DW-1:0] abs_re, abs_im, mag_max, mag_min;
  logic [DW:0]   mag_sum;

  // Two's complement negate of the most negative value yields 2^(DW-1) read as unsigned.
  always_comb begin
    abs_re  = out_real[DW-1] ? (~out_real + 1'b1) : out_real;
    abs_im  = out_imag[DW-1] ? (~out_imag + 1'b1) : out_imag;
    mag_max = (abs_re > abs_im) ? abs_re : abs_im;
    mag_min = (abs_re > abs_im) ? abs_im : abs_re;
    mag_sum = {1'b0, mag_max} + {2'b00, mag_min[DW-1:1]};
    out_mag = mag_sum[DW] ? '1 : mag_sum[DW-1:0];
  end
`endif

endmodule

// File: tb/tb_dft_bin_unloader.sv
module tb_dft_bin_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] real_value, imag_value;
  logic        bin_valid, bin_first;
  logic [31:0] out_real, out_imag;
  logic [3:0]  out_index;
  logic        out_valid, out_ready, out_last;
  logic        overflow, sync_err, clr_flags;

  int total = 0;
  int bad   = 0;

  dft_bin_unloader dut (
    .clk        (clk),
    .rst        (rst),
    .real_value (real_value),
    .imag_value (imag_value),
    .bin_valid  (bin_valid),
    .bin_first  (bin_first),
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .overflow   (overflow),
    .sync_err   (sync_err),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bin(input logic [31:0] re, input logic [31:0] im, input logic first);
    real_value = re;
    imag_value = im;
    bin_valid  = 1'b1;
    bin_first  = first;
    step();
    bin_valid  = 1'b0;
    bin_first  = 1'b0;
  endtask

  // Frame with re = base+k, im = -(base+k).
  task automatic send_frame(input int base);
    logic [31:0] v;
    for (int k = 0; k < 16; k++) begin
      v = 32'(base + k);
      send_bin(v, -v, k == 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (out_valid !== 1'b0 || out_real !== 32'd0 || out_imag !== 32'd0 || out_index !== 4'd0 ||
        out_last !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: got v=%b re=%h im=%h idx=%0d last=%b ovf=%b serr=%b, want all 0",
               out_valid, out_real, out_imag, out_index, out_last, overflow, sync_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL single_early_valid k=%0d: got %b want 0", k, out_valid);
      end
      v = 32'(k);
      send_bin(v, -v, k == 0);
    end
    for (int k = 0; k < 16; k++) begin
      v = 32'(k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v || out_imag !== -v ||
          out_last !== (k == 15)) begin
        bad++;
        $display("FAIL single_beat k=%0d: got v=%b idx=%0d re=%h im=%h last=%b want re=%h im=%h",
                 k, out_valid, out_index, out_real, out_imag, out_last, v, -v);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL single_after: got v=%b ovf=%b serr=%b want 0 0 0",
               out_valid, overflow, sync_err);
    end
  endtask

  task automatic test_backpressure_overflow();
    logic [31:0] v;
    int          base;
    out_ready = 1'b0;
    send_frame(100);
    send_frame(200);
    total++;
    if (out_valid !== 1'b1 || out_index !== 4'd0 || out_real !== 32'd100 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: got v=%b idx=%0d re=%h ovf=%b want 1 0 00000064 0",
               out_valid, out_index, out_real, overflow);
    end
    send_frame(300);
    total++;
    if (overflow !== 1'b1 || sync_err !== 1'b0 || out_real !== 32'd100 || out_index !== 4'd0) begin
      bad++;
      $display("FAIL bp_overflow: got ovf=%b serr=%b re=%h idx=%0d want 1 0 00000064 0",
               overflow, sync_err, out_real, out_index);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 32; j++) begin
      base = (j < 16) ? 100 : 200;
      v    = 32'(base + (j % 16));
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(j % 16) || out_real !== v || out_imag !== -v ||
          out_last !== ((j % 16) == 15)) begin
        bad++;
        $display("FAIL bp_beat j=%0d: got v=%b idx=%0d re=%h im=%h last=%b want re=%h",
                 j, out_valid, out_index, out_real, out_imag, out_last, v);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty: got v=%b want 0", out_valid);
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_clr: got ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_realign();
    logic [31:0] v;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      v = 32'(400 + k);
      send_bin(v, -v, k == 0);
    end
    total++;
    if (out_valid !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL realign_partial: got v=%b serr=%b want 0 0", out_valid, sync_err);
    end
    send_frame(500);
    total++;
    if (sync_err !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL realign_flag: got serr=%b ovf=%b want 1 0", sync_err, overflow);
    end
    for (int k = 0; k < 16; k++) begin
      v = 32'(500 + k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v || out_imag !== -v ||
          out_last !== (k == 15)) begin
        bad++;
        $display("FAIL realign_beat k=%0d: got v=%b idx=%0d re=%h im=%h last=%b want re=%h",
                 k, out_valid, out_index, out_real, out_imag, out_last, v);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL realign_empty: got v=%b want 0", out_valid);
    end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    total++;
    if (sync_err !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL realign_clr: got serr=%b ovf=%b want 0 0", sync_err, overflow);
    end
  endtask

  task automatic test_free_claim();
    logic [31:0] v;
    int          base, idx;
    out_ready = 1'b0;
    send_frame(600);
    send_frame(700);
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      v = 32'(600 + k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v || out_imag !== -v) begin
        bad++;
        $display("FAIL claim_a k=%0d: got v=%b idx=%0d re=%h im=%h want re=%h",
                 k, out_valid, out_index, out_real, out_imag, v);
      end
      step();
    end
    // First bin of the new frame arrives on the edge of frame A's final transfer.
    for (int c = 0; c < 16; c++) begin
      base = (c == 0) ? 600 : 700;
      idx  = (c == 0) ? 15 : c - 1;
      v    = 32'(base + idx);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(idx) || out_real !== v || out_imag !== -v ||
          out_last !== (idx == 15)) begin
        bad++;
        $display("FAIL claim_mix c=%0d: got v=%b idx=%0d re=%h im=%h last=%b want idx=%0d re=%h",
                 c, out_valid, out_index, out_real, out_imag, out_last, idx, v);
      end
      real_value = 32'(800 + c);
      imag_value = -(32'(800 + c));
      bin_valid  = 1'b1;
      bin_first  = (c == 0);
      step();
    end
    bin_valid = 1'b0;
    bin_first = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL claim_overflow: got ovf=%b want 0", overflow);
    end
    total++;
    if (out_valid !== 1'b1 || out_index !== 4'd15 || out_real !== 32'd715 || out_last !== 1'b1) begin
      bad++;
      $display("FAIL claim_b_last: got v=%b idx=%0d re=%h last=%b want 1 15 000002cb 1",
               out_valid, out_index, out_real, out_last);
    end
    step();
    for (int k = 0; k < 16; k++) begin
      v = 32'(800 + k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v || out_imag !== -v ||
          out_last !== (k == 15)) begin
        bad++;
        $display("FAIL claim_c k=%0d: got v=%b idx=%0d re=%h im=%h last=%b want re=%h",
                 k, out_valid, out_index, out_real, out_imag, out_last, v);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL claim_empty: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] v;
    out_ready = 1'b0;
    send_frame(900);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = 32'(900 + k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v) begin
        bad++;
        $display("FAIL rstmid_pre k=%0d: got v=%b idx=%0d re=%h want re=%h",
                 k, out_valid, out_index, out_real, v);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || out_real !== 32'd0 || out_imag !== 32'd0 || out_index !== 4'd0 ||
        out_last !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_zero: got v=%b re=%h im=%h idx=%0d last=%b ovf=%b serr=%b want 0",
               out_valid, out_real, out_imag, out_index, out_last, overflow, sync_err);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_stale: got v=%b want 0", out_valid);
    end
    send_frame(1000);
    for (int k = 0; k < 16; k++) begin
      v = 32'(1000 + k);
      total++;
      if (out_valid !== 1'b1 || out_index !== 4'(k) || out_real !== v || out_imag !== -v ||
          out_last !== (k == 15)) begin
        bad++;
        $display("FAIL rstmid_beat k=%0d: got v=%b idx=%0d re=%h im=%h last=%b want re=%h",
                 k, out_valid, out_index, out_real, out_imag, out_last, v);
      end
      step();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_empty: got v=%b want 0", out_valid);
    end
  endtask

  initial begin
    rst        = 1'b1;
    real_value = '0;
    imag_value = '0;
    bin_valid  = 1'b0;
    bin_first  = 1'b0;
    out_ready  = 1'b0;
    clr_flags  = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure_overflow();
    test_realign();
    test_free_claim();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
